count_seq_monitor: RTL and testbench

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

---
 rtl/count_seq_monitor.sv | 157 +++++++++++++++
 tb/tb_count_seq_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
// Watches the output of an upstream 3-bit up counter and decides whether it
// is stepping cleanly. After LOCK_LEN consecutive good increments the monitor
// declares LOCKED. While locked it counts 7->0 wraps and flags any sequence
// break as an error, then drops back to SYNC to reacquire.
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset
//   count_in    3-bit count value from the upstream counter
//   sample_en   count_in is valid and sampled on this edge
//   clr_err     synchronous clear of err and err_count
//   locked      high while the FSM is in LOCKED
//   wrap_pulse  one-cycle pulse after each accepted 7->0 step while LOCKED
//   wrap_count  saturating count of wrap_pulse events
//   err         sticky flag, set on a sequence break while LOCKED
//   err_count   saturating count of sequence breaks while LOCKED
//   state       FSM state: IDLE=0, SYNC=1, LOCKED=2

module count_seq_monitor #(
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       count_in,
    input  logic             sample_en,
    input  logic             clr_err,
    output logic             locked,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_count,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_LEN_C = 4'(LOCK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic             locked_q, locked_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             is_good;
    logic             is_hold;
    logic [3:0]       good_inc;

    // Classification of the current sample against the previous one; the
    // 3-bit add wraps naturally so 7 followed by 0 counts as a good step.
    assign is_good  = (count_in == prev_q + 3'd1);
    assign is_hold  = (count_in == prev_q);
    assign good_inc = good_cnt_q + 4'd1;

    // Next-state and next-output logic. clr_err is applied first so that a
    // simultaneous LOCKED error overrides it and leaves err_count at one.
    // wrap_pulse defaults low every cycle, which keeps it a single-cycle pulse
    // even when sample_en is idle.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_cnt_d   = good_cnt_q;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        err_d        = err_q;
        err_count_d  = err_count_q;

        if (clr_err) begin
            err_d       = 1'b0;
            err_count_d = '0;
        end

        if (sample_en) begin
            prev_d = count_in;
            case (state_q)
                IDLE: begin
                    good_cnt_d = 4'd0;
                    state_d    = SYNC;
                end
                SYNC: begin
                    if (is_good) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_LEN_C) begin
                            state_d = LOCKED;
                        end
                    end else if (!is_hold) begin
                        good_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_good) begin
                        if (prev_q == 3'd7) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_count_q != CNT_MAX) begin
                                wrap_count_d = wrap_count_q + CNT_ONE;
                            end
                        end
                    end else if (!is_hold) begin
                        err_d      = 1'b1;
                        good_cnt_d = 4'd0;
                        state_d    = SYNC;
                        if (err_count_d != CNT_MAX) begin
                            err_count_d = err_count_d + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= 3'd0;
            good_cnt_q   <= 4'd0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign state      = state_q;
    assign locked     = locked_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign err        = err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor
// Directed bench for count_seq_monitor with LOCK_LEN=4 and CNT_W=2 so that
// statistics saturation is reachable in a few dozen samples. A vector table
// covers locking, gating, holds, errors and clr_err; hand-written sequences
// cover repeated wraps with saturation and reset in the middle of SYNC.

module tb_count_seq_monitor;

    localparam int LOCK_LEN = 4;
    localparam int CNT_W    = 2;

    logic             clk;
    logic             reset;
    logic [2:0]       count_in;
    logic             sample_en;
    logic             clr_err;
    logic             locked;
    logic             wrap_pulse;
    logic [CNT_W-1:0] wrap_count;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] cnt;
        logic       clr;
        logic [1:0] e_state;
        logic       e_locked;
        logic       e_wp;
        logic [1:0] e_wc;
        logic       e_err;
        logic [1:0] e_ec;
    } vec_t;

    vec_t vecs[32];

    count_seq_monitor #(
        .LOCK_LEN(LOCK_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .sample_en (sample_en),
        .clr_err   (clr_err),
        .locked    (locked),
        .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count),
        .err       (err),
        .err_count (err_count),
        .state     (state)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic en, input logic [2:0] cnt,
                                input logic clr, input logic [1:0] st, input logic lk,
                                input logic wp, input logic [1:0] wc, input logic er,
                                input logic [1:0] ec);
        vec_t v;
        v.rst = rst; v.en = en; v.cnt = cnt; v.clr = clr;
        v.e_state = st; v.e_locked = lk; v.e_wp = wp; v.e_wc = wc;
        v.e_err = er; v.e_ec = ec;
        return v;
    endfunction

    // Drive one set of inputs, let one rising edge take them, and settle
    task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] cnt,
                                 input logic clr);
        reset     = rst;
        sample_en = en;
        count_in  = cnt;
        clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic cmpField(input string name, input string field, input int act,
                            input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s %s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] e_state,
                               input logic e_locked, input logic e_wp,
                               input logic [1:0] e_wc, input logic e_err,
                               input logic [1:0] e_ec);
        cmpField(name, "state",      int'(state),      int'(e_state));
        cmpField(name, "locked",     int'(locked),     int'(e_locked));
        cmpField(name, "wrap_pulse", int'(wrap_pulse), int'(e_wp));
        cmpField(name, "wrap_count", int'(wrap_count), int'(e_wc));
        cmpField(name, "err",        int'(err),        int'(e_err));
        cmpField(name, "err_count",  int'(err_count),  int'(e_ec));
    endtask

    initial begin
        logic [2:0] wrap_seq [8];
        logic [1:0] wc_exp;

        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        sample_en = 1'b0;
        count_in  = 3'd0;
        clr_err   = 1'b0;

        //               rst en cnt clr  state lk wp wc er ec
        vecs[0]  = mk(1, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0); // reset
        vecs[1]  = mk(0, 1, 3'd0, 0, 2'd1, 0, 0, 2'd0, 0, 2'd0); // IDLE -> SYNC
        vecs[2]  = mk(0, 1, 3'd1, 0, 2'd1, 0, 0, 2'd0, 0, 2'd0);
        vecs[3]  = mk(0, 1, 3'd2, 0, 2'd1, 0, 0, 2'd0, 0, 2'd0);
        vecs[4]  = mk(0, 1, 3'd3, 0, 2'd1, 0, 0, 2'd0, 0, 2'd0);
        vecs[5]  = mk(0, 1, 3'd4, 0, 2'd2, 1, 0, 2'd0, 0, 2'd0); // 4th good -> LOCKED
        vecs[6]  = mk(0, 0, 3'd7, 0, 2'd2, 1, 0, 2'd0, 0, 2'd0); // gated: would be BAD
        vecs[7]  = mk(0, 1, 3'd5, 0, 2'd2, 1, 0, 2'd0, 0, 2'd0);
        vecs[8]  = mk(0, 1, 3'd6, 0, 2'd2, 1, 0, 2'd0, 0, 2'd0);
        vecs[9]  = mk(0, 1, 3'd7, 0, 2'd2, 1, 0, 2'd0, 0, 2'd0);
        vecs[10] = mk(0, 1, 3'd0, 0, 2'd2, 1, 1, 2'd1, 0, 2'd0); // wrap
        vecs[11] = mk(0, 0, 3'd0, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0); // pulse is one cycle
        vecs[12] = mk(0, 1, 3'd1, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0);
        vecs[13] = mk(0, 1, 3'd1, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0); // hold
        vecs[14] = mk(0, 0, 3'd1, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0);
        vecs[15] = mk(0, 1, 3'd1, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0); // hold
        vecs[16] = mk(0, 1, 3'd2, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0);
        vecs[17] = mk(0, 1, 3'd3, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0);
        vecs[18] = mk(0, 1, 3'd5, 0, 2'd1, 0, 0, 2'd1, 1, 2'd1); // LOCKED BAD
        vecs[19] = mk(0, 1, 3'd6, 0, 2'd1, 0, 0, 2'd1, 1, 2'd1);
        vecs[20] = mk(0, 1, 3'd7, 0, 2'd1, 0, 0, 2'd1, 1, 2'd1);
        vecs[21] = mk(0, 1, 3'd0, 0, 2'd1, 0, 0, 2'd1, 1, 2'd1); // no wrap in SYNC
        vecs[22] = mk(0, 1, 3'd1, 0, 2'd2, 1, 0, 2'd1, 1, 2'd1); // relocked
        vecs[23] = mk(0, 1, 3'd4, 1, 2'd1, 0, 0, 2'd1, 1, 2'd1); // error beats clr_err
        vecs[24] = mk(0, 0, 3'd4, 1, 2'd1, 0, 0, 2'd1, 0, 2'd0); // clr_err alone
        vecs[25] = mk(0, 1, 3'd6, 0, 2'd1, 0, 0, 2'd1, 0, 2'd0); // SYNC BAD, no err
        vecs[26] = mk(0, 1, 3'd6, 0, 2'd1, 0, 0, 2'd1, 0, 2'd0); // hold
        vecs[27] = mk(0, 1, 3'd7, 0, 2'd1, 0, 0, 2'd1, 0, 2'd0);
        vecs[28] = mk(0, 1, 3'd7, 0, 2'd1, 0, 0, 2'd1, 0, 2'd0); // hold in SYNC
        vecs[29] = mk(0, 1, 3'd0, 0, 2'd1, 0, 0, 2'd1, 0, 2'd0);
        vecs[30] = mk(0, 1, 3'd1, 0, 2'd1, 0, 0, 2'd1, 0, 2'd0); // only 3 goods
        vecs[31] = mk(0, 1, 3'd2, 0, 2'd2, 1, 0, 2'd1, 0, 2'd0); // 4th good -> LOCKED

        for (int i = 0; i < 32; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].cnt, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_locked,
                        vecs[i].e_wp, vecs[i].e_wc, vecs[i].e_err, vecs[i].e_ec);
        end

        // Five full laps while LOCKED: wrap_count saturates at 3, and the
        // pulse is low on the sample right after each wrap.
        wrap_seq = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        wc_exp   = 2'd1;
        for (int w = 0; w < 5; w++) begin
            for (int s = 0; s < 8; s++) begin
                applyStimulus(1'b0, 1'b1, wrap_seq[s], 1'b0);
                if (wrap_seq[s] == 3'd0) begin
                    if (wc_exp != 2'd3) wc_exp = wc_exp + 2'd1;
                    cmpField($sformatf("wrap%0d", w), "wrap_pulse", int'(wrap_pulse), 1);
                    cmpField($sformatf("wrap%0d", w), "wrap_count", int'(wrap_count),
                             int'(wc_exp));
                end else if (wrap_seq[s] == 3'd1) begin
                    cmpField($sformatf("wrap%0d_after", w), "wrap_pulse",
                             int'(wrap_pulse), 0);
                end
            end
        end
        checkOutput("wrap_sat", 2'd2, 1'b1, 1'b0, 2'd3, 1'b0, 2'd0);

        // Break lock, accumulate part of a SYNC run, then reset mid-SYNC
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0);
        checkOutput("break", 2'd1, 1'b0, 1'b0, 2'd3, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b1, 3'd6, 1'b0);
        checkOutput("sync_good", 2'd1, 1'b0, 1'b0, 2'd3, 1'b1, 2'd1);
        applyStimulus(1'b1, 1'b1, 3'd7, 1'b0);
        checkOutput("reset_mid_sync", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        // Relocking needs a fresh IDLE sample plus four good steps
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0);
        checkOutput("relock_idle", 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0);
        checkOutput("relock_3good", 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0);
        checkOutput("relock_done", 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
